// File: rtl/iic_cntr_axil_slave.sv
// AXI4-Lite register bank for the IIC controller: CTRL, TXDATA, PRESCALE, STATUS.
// Independent write and read channels; start/busy/done handshake toward the IIC engine.
module iic_cntr_axil_slave #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
  parameter logic [15:0] PRESCALE_RST       = 16'd250
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]                      s_axi_awprot,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]                      s_axi_arprot,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic                            iic_start,
  output logic                            iic_rw,
  output logic [6:0]                      iic_dev_addr,
  output logic [7:0]                      iic_wdata,
  output logic [15:0]                     iic_prescale,
  input  logic                            iic_busy,
  input  logic                            iic_done,
  input  logic                            iic_nack,
  input  logic [7:0]                      iic_rdata,
  output logic                            irq
);

  logic                          aw_full_q, aw_full_d, w_full_q, w_full_d;
  logic [1:0]                    aw_sel_q, aw_sel_d;
  logic [15:0]                   w_data_q, w_data_d;
  logic [1:0]                    w_strb_q, w_strb_d;
  logic                          bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic                          aw_rdy_q, aw_rdy_d, w_rdy_q, w_rdy_d, ar_rdy_q, ar_rdy_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d, rd_word;
  logic                          irq_en_q, irq_en_d, rw_q, rw_d, start_q, start_d, irq_q, irq_d;
  logic [6:0]                    dev_addr_q, dev_addr_d;
  logic [7:0]                    tx_byte_q, tx_byte_d, rx_byte_q, rx_byte_d;
  logic [15:0]                   prescale_q, prescale_d;
  logic                          done_q, done_d, nack_q, nack_d;
  logic                          commit;
  logic                          unused_bits;

  assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr, s_axi_araddr,
                         s_axi_wdata, s_axi_wstrb};

  assign commit = aw_full_q & w_full_q & ~bvalid_q;

  // Read data comes from the current register state, ahead of any same-edge write.
  always_comb begin
    rd_word = '0;
    case (s_axi_araddr[3:2])
      2'd0:    rd_word = {29'h0, rw_q, irq_en_q, 1'b0};
      2'd1:    rd_word = {16'h0, tx_byte_q, 1'b0, dev_addr_q};
      2'd2:    rd_word = {16'h0, prescale_q};
      default: rd_word = {16'h0, rx_byte_q, 5'h0, nack_q, done_q, iic_busy};
    endcase
  end

  always_comb begin
    aw_full_d  = aw_full_q;
    aw_sel_d   = aw_sel_q;
    w_full_d   = w_full_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    bvalid_d   = bvalid_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    irq_en_d   = irq_en_q;
    rw_d       = rw_q;
    dev_addr_d = dev_addr_q;
    tx_byte_d  = tx_byte_q;
    prescale_d = prescale_q;
    done_d     = done_q;
    nack_d     = nack_q;
    rx_byte_d  = rx_byte_q;
    start_d    = 1'b0;

    if (s_axi_awvalid && aw_rdy_q) begin
      aw_full_d = 1'b1;
      aw_sel_d  = s_axi_awaddr[3:2];
    end
    if (s_axi_wvalid && w_rdy_q) begin
      w_full_d = 1'b1;
      w_data_d = s_axi_wdata[15:0];
      w_strb_d = s_axi_wstrb[1:0];
    end

    if (commit) begin
      bvalid_d = 1'b1;
      case (aw_sel_q)
        2'd0: begin
          if (w_strb_q[0]) begin
            irq_en_d = w_data_q[1];
            rw_d     = w_data_q[2];
            start_d  = w_data_q[0] & ~iic_busy;
          end
        end
        2'd1: begin
          if (w_strb_q[0]) dev_addr_d = w_data_q[6:0];
          if (w_strb_q[1]) tx_byte_d = w_data_q[15:8];
        end
        2'd2: begin
          if (w_strb_q[0]) prescale_d[7:0] = w_data_q[7:0];
          if (w_strb_q[1]) prescale_d[15:8] = w_data_q[15:8];
        end
        default: begin
          if (w_strb_q[0] && w_data_q[1]) done_d = 1'b0;
          if (w_strb_q[0] && w_data_q[2]) nack_d = 1'b0;
        end
      endcase
    end

    if (bvalid_q && s_axi_bready) begin
      bvalid_d = 1'b0;
      aw_full_d = 1'b0;
      w_full_d = 1'b0;
    end

    // Applied after the W1C so a completion on the same edge wins.
    if (iic_done) begin
      done_d    = 1'b1;
      rx_byte_d = iic_rdata;
      if (iic_nack) nack_d = 1'b1;
    end

    if (s_axi_arvalid && ar_rdy_q) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_word;
    end else if (rvalid_q && s_axi_rready) begin
      rvalid_d = 1'b0;
    end

    aw_rdy_d = ~aw_full_d & ~bvalid_d;
    w_rdy_d  = ~w_full_d & ~bvalid_d;
    ar_rdy_d = ~rvalid_d;
    irq_d    = done_q & irq_en_q;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_full_q  <= 1'b0;
      aw_sel_q   <= 2'd0;
      w_full_q   <= 1'b0;
      w_data_q   <= 16'h0;
      w_strb_q   <= 2'd0;
      bvalid_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      aw_rdy_q   <= 1'b0;
      w_rdy_q    <= 1'b0;
      ar_rdy_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      rw_q       <= 1'b0;
      dev_addr_q <= 7'h0;
      tx_byte_q  <= 8'h0;
      prescale_q <= PRESCALE_RST;
      done_q     <= 1'b0;
      nack_q     <= 1'b0;
      rx_byte_q  <= 8'h0;
      start_q    <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      aw_full_q  <= aw_full_d;
      aw_sel_q   <= aw_sel_d;
      w_full_q   <= w_full_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      aw_rdy_q   <= aw_rdy_d;
      w_rdy_q    <= w_rdy_d;
      ar_rdy_q   <= ar_rdy_d;
      irq_en_q   <= irq_en_d;
      rw_q       <= rw_d;
      dev_addr_q <= dev_addr_d;
      tx_byte_q  <= tx_byte_d;
      prescale_q <= prescale_d;
      done_q     <= done_d;
      nack_q     <= nack_d;
      rx_byte_q  <= rx_byte_d;
      start_q    <= start_d;
      irq_q      <= irq_d;
    end
  end

  assign s_axi_awready = aw_rdy_q;
  assign s_axi_wready  = w_rdy_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_arready = ar_rdy_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = 2'b00;
  assign iic_start     = start_q;
  assign iic_rw        = rw_q;
  assign iic_dev_addr  = dev_addr_q;
  assign iic_wdata     = tx_byte_q;
  assign iic_prescale  = prescale_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_iic_cntr_axil_slave.sv
// Randomised bench for iic_cntr_axil_slave against a register-level reference model.
module tb_iic_cntr_axil_slave;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [3:0]  s_axi_awaddr, s_axi_araddr;
  logic [2:0]  s_axi_awprot, s_axi_arprot;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [31:0] s_axi_wdata, s_axi_rdata;
  logic [3:0]  s_axi_wstrb;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rvalid, s_axi_rready;
  logic        iic_start, iic_rw, iic_busy, iic_done, iic_nack, irq;
  logic [6:0]  iic_dev_addr;
  logic [7:0]  iic_wdata, iic_rdata;
  logic [15:0] iic_prescale;

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;
  int b_cnt = 0;

  // Reference model state
  logic        m_irq_en, m_rw, m_done, m_nack;
  logic [6:0]  m_dev;
  logic [7:0]  m_tx, m_rx;
  logic [15:0] m_pre;

  iic_cntr_axil_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4),
    .PRESCALE_RST(16'd250)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .iic_start(iic_start), .iic_rw(iic_rw), .iic_dev_addr(iic_dev_addr),
    .iic_wdata(iic_wdata), .iic_prescale(iic_prescale),
    .iic_busy(iic_busy), .iic_done(iic_done), .iic_nack(iic_nack),
    .iic_rdata(iic_rdata), .irq(irq)
  );

  always #5 ACLK = ~ACLK;

  always @(negedge ACLK) begin
    if (iic_start) start_cnt++;
    if (s_axi_bvalid && s_axi_bready) b_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_irq_en = 0; m_rw = 0; m_done = 0; m_nack = 0;
    m_dev = 0; m_tx = 0; m_rx = 0; m_pre = 16'd250;
  endtask

  task automatic model_write(input int sel, input logic [31:0] d, input logic [3:0] s,
                             input logic busy, output int exp_start);
    exp_start = 0;
    if (sel == 0 && s[0]) begin
      m_irq_en = d[1];
      m_rw = d[2];
      exp_start = (d[0] && !busy) ? 1 : 0;
    end
    if (sel == 1 && s[0]) m_dev = d[6:0];
    if (sel == 1 && s[1]) m_tx = d[15:8];
    if (sel == 2 && s[0]) m_pre = (m_pre & 16'hFF00) | 16'(d & 32'hFF);
    if (sel == 2 && s[1]) m_pre = (m_pre & 16'h00FF) | 16'(d & 32'hFF00);
    if (sel == 3 && s[0] && d[1]) m_done = 0;
    if (sel == 3 && s[0] && d[2]) m_nack = 0;
  endtask

  function automatic logic [31:0] model_read(input int sel, input logic busy);
    case (sel)
      0:       return 32'(m_irq_en) * 2 + 32'(m_rw) * 4;
      1:       return 32'(m_tx) * 256 + 32'(m_dev);
      2:       return 32'(m_pre);
      default: return 32'(m_rx) * 256 + 32'(m_nack) * 4 + 32'(m_done) * 2 + 32'(busy);
    endcase
  endfunction

  // Drives one write; AW/W raised after the given delays. resp is X on timeout.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, output logic [1:0] resp,
                           output int starts);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs, got = 0;
    int s0 = start_cnt;
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
    resp = 2'bxx;
    for (int cyc = 0; cyc < 60 && !(aw_done && w_done); cyc++) begin
      s_axi_awvalid = !aw_done && cyc >= aw_dly;
      s_axi_wvalid  = !w_done && cyc >= w_dly;
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      @(posedge ACLK); #1;
      if (aw_hs) aw_done = 1;
      if (w_hs) w_done = 1;
    end
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    if (aw_done && w_done) begin
      for (int cyc = 0; cyc < 60 && !got; cyc++) begin
        if (s_axi_bvalid) begin
          resp = s_axi_bresp;
          got = 1;
        end
        @(posedge ACLK); #1;
      end
    end
    starts = start_cnt - s0;
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    bit hs = 0, got = 0;
    data = 'x; resp = 2'bxx;
    s_axi_araddr = addr; s_axi_arvalid = 1;
    for (int cyc = 0; cyc < 60 && !hs; cyc++) begin
      hs = s_axi_arready;
      @(posedge ACLK); #1;
    end
    s_axi_arvalid = 0;
    if (hs) begin
      for (int cyc = 0; cyc < 60 && !got; cyc++) begin
        if (s_axi_rvalid) begin
          data = s_axi_rdata; resp = s_axi_rresp; got = 1;
        end
        @(posedge ACLK); #1;
      end
    end
  endtask

  task automatic test_reset();
    logic [53:0] act;
    ARESET = 1;
    repeat (3) @(posedge ACLK);
    #1;
    act = {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, s_axi_bresp,
           s_axi_rresp, s_axi_rdata, iic_start, irq, iic_prescale};
    checks++;
    if (act !== {9'h0, 32'h0, 2'b00, 16'd250}) begin
      errors++;
      $display("FAIL reset_outputs: got %h want %h", act, {9'h0, 32'h0, 2'b00, 16'd250});
    end
    checks++;
    if ({iic_rw, iic_dev_addr, iic_wdata} !== 16'h0) begin
      errors++;
      $display("FAIL reset_iic_regs: got %h want 0", {iic_rw, iic_dev_addr, iic_wdata});
    end
    ARESET = 0;
    model_reset();
    @(posedge ACLK); #1;
    checks++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
      errors++;
      $display("FAIL ready_after_reset: got %b want 111",
               {s_axi_awready, s_axi_wready, s_axi_arready});
    end
  endtask

  task automatic test_regmap();
    logic [1:0] resp; logic [31:0] rd; int st, es;
    iic_busy = 0;
    for (int i = 0; i < 4; i++) begin
      axi_write(4'(i * 4), 32'(i + 1), 4'hF, 0, 0, resp, st);
      model_write(i, 32'(i + 1), 4'hF, 0, es);
      checks++;
      if (resp !== 2'b00 || st !== es) begin
        errors++;
        $display("FAIL regmap_write%0d: bresp=%b starts=%0d want 00/%0d", i, resp, st, es);
      end
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), rd, resp);
      checks++;
      if (rd !== model_read(i, iic_busy) || resp !== 2'b00) begin
        errors++;
        $display("FAIL regmap_read%0d: got %h/%b want %h/00", i, rd, resp, model_read(i, iic_busy));
      end
    end
  endtask

  task automatic test_start_done();
    logic [1:0] resp; logic [31:0] rd; int st, es;
    iic_busy = 0;
    axi_write(4'h4, 32'h0000A550, 4'hF, 0, 0, resp, st);
    model_write(1, 32'h0000A550, 4'hF, 0, es);
    axi_write(4'h0, 32'h3, 4'hF, 0, 0, resp, st);
    model_write(0, 32'h3, 4'hF, 0, es);
    checks++;
    if (st !== 1 || iic_dev_addr !== 7'h50 || iic_wdata !== 8'hA5) begin
      errors++;
      $display("FAIL start_pulse: starts=%0d dev=%h wdata=%h want 1/50/a5", st, iic_dev_addr,
               iic_wdata);
    end
    iic_done = 1; iic_rdata = 8'h3C; iic_nack = 1;
    @(posedge ACLK); #1;
    iic_done = 0; iic_nack = 0;
    m_done = 1; m_nack = 1; m_rx = 8'h3C;
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_latency: got %b want 0", irq);
    end
    @(posedge ACLK); #1;
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_set: got %b want 1", irq);
    end
    axi_read(4'hC, rd, resp);
    checks++;
    if (rd !== model_read(3, 0) || rd !== 32'h00003C06) begin
      errors++;
      $display("FAIL status_done: got %h want 00003c06", rd);
    end
    axi_write(4'hC, 32'h6, 4'hF, 0, 0, resp, st);
    model_write(3, 32'h6, 4'hF, 0, es);
    axi_read(4'hC, rd, resp);
    repeat (2) @(posedge ACLK);
    #1;
    checks++;
    if (rd !== model_read(3, 0) || irq !== 1'b0) begin
      errors++;
      $display("FAIL status_w1c: got %h irq=%b want %h irq=0", rd, irq, model_read(3, 0));
    end
  endtask

  task automatic test_order();
    logic [1:0] resp; logic [31:0] rd, d; int st, es, b0;
    for (int k = 0; k < 2; k++) begin
      d = $urandom;
      b0 = b_cnt;
      axi_write(4'h8, d, 4'hF, (k == 0) ? 5 : 0, (k == 0) ? 0 : 5, resp, st);
      model_write(2, d, 4'hF, iic_busy, es);
      repeat (3) @(posedge ACLK);
      #1;
      checks++;
      if (b_cnt - b0 !== 1 || s_axi_bvalid !== 1'b0 || resp !== 2'b00) begin
        errors++;
        $display("FAIL order%0d_bbeats: got %0d bvalid=%b want 1/0", k, b_cnt - b0, s_axi_bvalid);
      end
      axi_read(4'h8, rd, resp);
      checks++;
      if (rd !== model_read(2, iic_busy)) begin
        errors++;
        $display("FAIL order%0d_data: got %h want %h", k, rd, model_read(2, iic_busy));
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] resp; logic [31:0] rd, d; logic [3:0] s; int st, es, sel;
    for (int i = 0; i < 16; i++) begin
      sel = $urandom_range(0, 3);
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      iic_busy = 1'($urandom_range(0, 1));
      axi_write(4'(sel * 4 + $urandom_range(0, 3)), d, s, $urandom_range(0, 3),
                $urandom_range(0, 3), resp, st);
      model_write(sel, d, s, iic_busy, es);
      checks++;
      if (resp !== 2'b00 || st !== es) begin
        errors++;
        $display("FAIL rand%0d_write: bresp=%b starts=%0d want 00/%0d", i, resp, st, es);
      end
      sel = $urandom_range(0, 3);
      axi_read(4'(sel * 4 + $urandom_range(0, 3)), rd, resp);
      checks++;
      if (rd !== model_read(sel, iic_busy) || resp !== 2'b00) begin
        errors++;
        $display("FAIL rand%0d_read sel%0d: got %h want %h", i, sel, rd, model_read(sel, iic_busy));
      end
    end
    repeat (2) @(posedge ACLK);
    #1;
    checks++;
    if ({irq, iic_prescale, iic_rw, iic_dev_addr, iic_wdata} !==
        {m_done & m_irq_en, m_pre, m_rw, m_dev, m_tx}) begin
      errors++;
      $display("FAIL rand_outputs: got %h want %h", {irq, iic_prescale, iic_rw, iic_dev_addr,
               iic_wdata}, {m_done & m_irq_en, m_pre, m_rw, m_dev, m_tx});
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] snap, d, exp; int es;
    bit stable = 1;
    d = $urandom;
    exp = model_read(1, iic_busy);
    s_axi_bready = 0; s_axi_rready = 0;
    s_axi_awaddr = 4'h8; s_axi_wdata = d; s_axi_wstrb = 4'hF; s_axi_araddr = 4'h4;
    s_axi_awvalid = 1; s_axi_wvalid = 1; s_axi_arvalid = 1;
    @(posedge ACLK); #1;
    s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0;
    model_write(2, d, 4'hF, iic_busy, es);
    @(posedge ACLK); #1;
    snap = s_axi_rdata;
    checks++;
    if (s_axi_bvalid !== 1'b1 || s_axi_rvalid !== 1'b1 || snap !== exp) begin
      errors++;
      $display("FAIL bp_start: bvalid=%b rvalid=%b rdata=%h want 1/1/%h", s_axi_bvalid,
               s_axi_rvalid, snap, exp);
    end
    s_axi_awvalid = 1; s_axi_arvalid = 1;
    for (int c = 0; c < 10; c++) begin
      if (s_axi_bvalid !== 1'b1 || s_axi_rvalid !== 1'b1 || s_axi_rdata !== snap ||
          s_axi_awready !== 1'b0 || s_axi_arready !== 1'b0) stable = 0;
      @(posedge ACLK); #1;
    end
    s_axi_awvalid = 0; s_axi_arvalid = 0;
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL bp_stall: got unstable want stable for 10 cycles");
    end
    s_axi_bready = 1; s_axi_rready = 1;
    @(posedge ACLK); #1;
    checks++;
    if ({s_axi_bvalid, s_axi_rvalid, s_axi_awready, s_axi_arready} !== 4'b0011) begin
      errors++;
      $display("FAIL bp_release: got %b want 0011",
               {s_axi_bvalid, s_axi_rvalid, s_axi_awready, s_axi_arready});
    end
  endtask

  task automatic test_busy_w1c();
    logic [1:0] resp; logic [31:0] rd; logic [7:0] r; int st, es, b0;
    iic_busy = 1;
    axi_write(4'h0, 32'h3, 4'hF, 0, 0, resp, st);
    model_write(0, 32'h3, 4'hF, 1, es);
    checks++;
    if (st !== 0) begin
      errors++;
      $display("FAIL busy_start: starts=%0d want 0", st);
    end
    r = 8'($urandom);
    iic_done = 1; iic_rdata = r;
    @(posedge ACLK); #1;
    iic_done = 0;
    m_done = 1; m_rx = r;
    b0 = b_cnt;
    s_axi_awaddr = 4'hC; s_axi_wdata = 32'h2; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1; s_axi_wvalid = 1;
    @(posedge ACLK); #1;
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    r = 8'($urandom);
    iic_done = 1; iic_rdata = r;
    @(posedge ACLK); #1;
    iic_done = 0;
    model_write(3, 32'h2, 4'hF, 1, es);
    m_done = 1; m_rx = r;
    @(posedge ACLK); #1;
    checks++;
    if (b_cnt - b0 !== 1) begin
      errors++;
      $display("FAIL w1c_bbeat: got %0d want 1", b_cnt - b0);
    end
    axi_read(4'hC, rd, resp);
    checks++;
    if (rd !== model_read(3, 1) || rd[1] !== 1'b1) begin
      errors++;
      $display("FAIL w1c_set_wins: got %h want %h", rd, model_read(3, 1));
    end
  endtask

  task automatic test_reset_midwrite();
    logic [1:0] resp; logic [31:0] rd; int st, es, b0;
    axi_write(4'h0, 32'h2, 4'hF, 0, 0, resp, st);
    model_write(0, 32'h2, 4'hF, iic_busy, es);
    axi_write(4'h8, 32'h1234, 4'hF, 0, 0, resp, st);
    model_write(2, 32'h1234, 4'hF, iic_busy, es);
    s_axi_awaddr = 4'h8; s_axi_awvalid = 1;
    @(posedge ACLK); #1;
    s_axi_awvalid = 0;
    ARESET = 1;
    @(posedge ACLK); #1;
    ARESET = 0;
    model_reset();
    b0 = b_cnt;
    checks++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, s_axi_rdata,
         iic_start, irq, iic_prescale, iic_rw, iic_dev_addr, iic_wdata} !==
        {5'b0, 32'h0, 2'b00, 16'd250, 16'h0}) begin
      errors++;
      $display("FAIL midreset_outputs: rdata=%h irq=%b prescale=%0d bvalid=%b want 0/0/250/0",
               s_axi_rdata, irq, iic_prescale, s_axi_bvalid);
    end
    repeat (5) @(posedge ACLK);
    #1;
    checks++;
    if (b_cnt - b0 !== 0 || s_axi_bvalid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_no_b: beats=%0d bvalid=%b want 0/0", b_cnt - b0, s_axi_bvalid);
    end
    axi_read(4'h8, rd, resp);
    checks++;
    if (rd !== model_read(2, iic_busy)) begin
      errors++;
      $display("FAIL midreset_prescale: got %h want %h", rd, model_read(2, iic_busy));
    end
  endtask

  initial begin
    ARESET = 1;
    s_axi_awaddr = 0; s_axi_awprot = 0; s_axi_awvalid = 0;
    s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_wvalid = 0; s_axi_bready = 1;
    s_axi_araddr = 0; s_axi_arprot = 0; s_axi_arvalid = 0; s_axi_rready = 1;
    iic_busy = 0; iic_done = 0; iic_nack = 0; iic_rdata = 0;
    model_reset();
    test_reset();
    test_regmap();
    test_start_done();
    test_order();
    test_random();
    test_backpressure();
    test_busy_w1c();
    test_reset_midwrite();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
